// File: rtl/ins_ram_writer.sv
`timescale 1ns/1ps
// ins_ram_writer
// Loads the instruction RAM from a 32-bit host stream. Consecutive beats are
// assembled into one INS_W-bit instruction word (beat k -> bits
// [k*BEAT_W +: BEAT_W], so beat 0 carries the opcode in [7:0]). Each completed
// word is written to sequential RAM addresses starting at base_addr. The
// address wraps from DEPTH-1 to 0.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   start                one-cycle pulse, accepted only while idle
//   base_addr, n_ins     first RAM address and instruction count
//   s_tdata/s_tvalid/
//   s_tready/s_tlast     beat stream; tlast marks the last beat of the load
//   ram_wen/ram_waddr/
//   ram_wdata            instruction RAM write port
//   busy                 high whenever not idle
//   done                 one-cycle pulse when the load finishes
//   err                  sticky tlast-mismatch flag, cleared by next start
//   n_written            instructions written in the current load
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// COLLECT | accepting beats into the assembly register
// WRITE   | one-cycle RAM write of the assembled word
// FIN     | done pulse (held one extra cycle first for a zero-count load)

module ins_ram_writer #(
    parameter int INS_W  = 512,
    parameter int BEAT_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [15:0]       n_ins,
    input  logic [BEAT_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic              ram_wen,
    output logic [AW-1:0]     ram_waddr,
    output logic [INS_W-1:0]  ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       n_written
);

    localparam int N_BEATS = INS_W / BEAT_W;
    localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q;
    logic [15:0]        remaining_q;
    logic [15:0]        n_written_q;
    logic               err_q;
    logic [BW-1:0]      beat_q;
    logic [INS_W-1:0]   word_q;
    logic               zero_wait_q;

    logic start_acc;
    logic beat_hs;
    logic last_beat;
    logic final_ins;

    assign start_acc = (state_q == S_IDLE) && start;
    assign beat_hs   = (state_q == S_COLLECT) && s_tvalid;
    assign last_beat = (beat_q == BW'(N_BEATS - 1));
    assign final_ins = (remaining_q == 16'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (n_ins == 16'd0) ? S_FIN : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (s_tvalid && last_beat) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = final_ins ? S_FIN : S_COLLECT;
            end
            S_FIN: begin
                // A zero-count load spends one silent cycle here so done
                // lands two cycles after start.
                if (!zero_wait_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q      <= '0;
            remaining_q <= '0;
            n_written_q <= '0;
            err_q       <= 1'b0;
            beat_q      <= '0;
            word_q      <= '0;
            zero_wait_q <= 1'b0;
        end else begin
            if (start_acc) begin
                addr_q      <= base_addr;
                remaining_q <= n_ins;
                n_written_q <= '0;
                err_q       <= 1'b0;
                beat_q      <= '0;
                zero_wait_q <= (n_ins == 16'd0);
            end

            if (beat_hs) begin
                word_q[beat_q*BEAT_W +: BEAT_W] <= s_tdata;
                if (!last_beat) begin
                    beat_q <= beat_q + 1'b1;
                end
                // tlast is legal only on the final beat of the final word,
                // and required there; any other combination is an error.
                if (s_tlast != (last_beat && final_ins)) begin
                    err_q <= 1'b1;
                end
            end

            if (state_q == S_WRITE) begin
                addr_q      <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                remaining_q <= remaining_q - 16'd1;
                n_written_q <= n_written_q + 16'd1;
                beat_q      <= '0;
            end

            if (state_q == S_FIN) begin
                zero_wait_q <= 1'b0;
            end
        end
    end

    assign s_tready  = (state_q == S_COLLECT);
    assign ram_wen   = (state_q == S_WRITE);
    assign ram_waddr = addr_q;
    assign ram_wdata = word_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN) && !zero_wait_q;
    assign err       = err_q;
    assign n_written = n_written_q;

endmodule

// File: tb/tb_ins_ram_writer.sv
`timescale 1ns/1ps
module tb_ins_ram_writer;

    localparam int INS_W  = 512;
    localparam int BEAT_W = 32;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int NB     = INS_W / BEAT_W;

    logic              clk;
    logic              rstn;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [15:0]       n_ins;
    logic [BEAT_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic              ram_wen;
    logic [AW-1:0]     ram_waddr;
    logic [INS_W-1:0]  ram_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       n_written;

    ins_ram_writer #(.INS_W(INS_W), .BEAT_W(BEAT_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .n_ins(n_ins),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .err(err), .n_written(n_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // write monitor, sampled on the falling edge
    int                wen_addr_q[$];
    logic [INS_W-1:0]  wen_data_q[$];
    int                wen_cyc_q[$];
    always @(negedge clk) begin
        if (ram_wen) begin
            wen_addr_q.push_back(int'(ram_waddr));
            wen_data_q.push_back(ram_wdata);
            wen_cyc_q.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [INS_W-1:0] act, input logic [INS_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int base;
        int n;
        int gap;        // 0 continuous, 2 toggle every other cycle, 3 random
        int err_beat;   // beat index given a stray tlast, -1 none
        bit miss_last;  // drop tlast from the final beat
        int mid_start;  // beat index at which a stray start is pulsed, -1 none
        bit fixed_pat;  // 0x03, 0x11111111, 0x22222222 ... beat pattern
        bit exp_err;
    } vec_t;

    task automatic run_load(input vec_t v, input string tag);
        logic [31:0]      beats[$];
        bit               lasts[$];
        logic [INS_W-1:0] word;
        int total, w0, idx, cnt, k, hsc, dc, nw, sc;
        bit vld, hold, acc, first;
        total = v.n * NB;
        for (int i = 0; i < total; i++) begin
            if (v.fixed_pat)
                beats.push_back((i % NB == 0) ? 32'h3 : 32'(32'h11111111 * (i % NB)));
            else
                beats.push_back($urandom);
            lasts.push_back(i == total - 1);
        end
        if (v.err_beat >= 0) lasts[v.err_beat] = 1'b1;
        if (v.miss_last && total > 0) lasts[total-1] = 1'b0;

        w0 = wen_addr_q.size();
        base_addr = AW'(v.base);
        n_ins     = 16'(v.n);
        start     = 1'b1;
        sc        = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
        chk({tag, " err_cleared"}, err, 0);
        chk({tag, " n_written_cleared"}, n_written, 0);
        chk({tag, " tready_after_start"}, s_tready, (v.n > 0));

        if (v.n == 0) begin
            chk({tag, " zero_done_early"}, done, 0);
            @(negedge clk);
            chk({tag, " zero_done_2cyc"}, done, 1);
            chk({tag, " zero_done_cycle"}, cyc - sc, 2);
            @(negedge clk);
            chk({tag, " zero_done_pulse"}, done, 0);
            chk({tag, " zero_idle"}, busy, 0);
            chk({tag, " zero_no_wen"}, wen_addr_q.size() - w0, 0);
            return;
        end

        idx = 0; cnt = 0; hold = 0; first = 1; hsc = 0;
        while (idx < total && cnt < 400 * v.n) begin
            case (v.gap)
                0:       vld = 1'b1;
                2:       vld = (cyc % 2 == 0);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            if (hold) vld = 1'b1;
            s_tvalid = vld;
            s_tdata  = beats[idx];
            s_tlast  = lasts[idx];
            if (idx == v.mid_start && vld) begin
                start     = 1'b1;
                base_addr = AW'(v.base + 77);
                n_ins     = 16'(v.n + 5);
            end
            acc  = vld && s_tready;
            hold = vld && !acc;
            if (acc) begin
                if (first) hsc = cyc;
                first = 0;
                idx++;
            end
            @(negedge clk);
            start = 1'b0;
            cnt++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk({tag, " beats_accepted"}, idx, total);

        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        dc = cyc;
        chk({tag, " done_seen"}, done, 1);
        chk({tag, " err"}, err, v.exp_err);
        chk({tag, " n_written"}, n_written, v.n);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " idle_after"}, busy, 0);

        nw = wen_addr_q.size() - w0;
        chk({tag, " write_count"}, nw, v.n);
        for (int i = 0; i < v.n && i < nw; i++) begin
            word = '0;
            for (int b = 0; b < NB; b++) word[b*BEAT_W +: BEAT_W] = beats[i*NB + b];
            chk($sformatf("%s addr[%0d]", tag, i), wen_addr_q[w0+i], (v.base + i) % DEPTH);
            chk($sformatf("%s data[%0d]", tag, i), wen_data_q[w0+i], word);
            if (v.gap == 0 && v.mid_start < 0)
                chk($sformatf("%s write_cycle[%0d]", tag, i), wen_cyc_q[w0+i] - hsc + 1, 17 * (i + 1));
        end
        if (nw > 0) begin
            chk({tag, " done_after_write"}, dc - wen_cyc_q[w0+nw-1], 1);
            if (v.fixed_pat) begin
                chk({tag, " opcode"}, wen_data_q[w0][7:0], 8'h03);
                chk({tag, " top_beat"}, wen_data_q[w0][511:480], beats[NB-1]);
            end
        end
    endtask

    vec_t vecs[8];
    vec_t rv;
    int   w0;
    int   idx;

    initial begin
        rstn = 1'b0; start = 1'b0; base_addr = '0; n_ins = '0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;

        //        base  n  gap eb  miss mid pat exp_err
        vecs[0] = '{5,    1, 0, -1, 0, -1, 1, 0};
        vecs[1] = '{100,  3, 0, -1, 0, -1, 0, 0};
        vecs[2] = '{1023, 2, 2, -1, 0, -1, 0, 0};
        vecs[3] = '{20,   2, 0,  7, 0, -1, 0, 1};
        vecs[4] = '{40,   1, 0, -1, 1, -1, 0, 1};
        vecs[5] = '{60,   2, 3, -1, 0, -1, 0, 0};
        vecs[6] = '{200,  2, 0, -1, 0,  5, 0, 0};
        vecs[7] = '{0,    0, 0, -1, 0, -1, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst s_tready", s_tready, 0);
        chk("rst ram_wen", ram_wen, 0);
        chk("rst ram_waddr", ram_waddr, 0);
        chk("rst ram_wdata", ram_wdata, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst n_written", n_written, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_load(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        for (int r = 0; r < 4; r++) begin
            rv = '{int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 3)), 3, -1, 0, -1, 0, 0};
            run_load(rv, $sformatf("rnd%0d", r));
        end

        // reset after 9 beats of a word
        base_addr = AW'(300); n_ins = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        for (int k = 0; k < 50 && idx < 9; k++) begin
            s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = 1'b0;
            if (s_tready) idx++;
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        chk("rstmid beats", idx, 9);
        w0 = wen_addr_q.size();
        rstn = 1'b0;
        #1;
        chk("rstmid s_tready", s_tready, 0);
        chk("rstmid ram_wen", ram_wen, 0);
        chk("rstmid ram_waddr", ram_waddr, 0);
        chk("rstmid ram_wdata", ram_wdata, 0);
        chk("rstmid busy", busy, 0);
        chk("rstmid done", done, 0);
        chk("rstmid err", err, 0);
        chk("rstmid n_written", n_written, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid no_wen", wen_addr_q.size() - w0, 0);
        rv = '{300, 1, 0, -1, 0, -1, 0, 0};
        run_load(rv, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ins_ram_writer.md
# ins_ram_writer

Loads the instruction RAM from a 32-bit host stream. It assembles consecutive beats into full `INS_RAM_DATA_WIDTH`-bit instruction words and writes each completed word to sequential instruction-RAM addresses. It sits between the host DMA/AXI-Stream path and the instruction RAM write port. It produces exactly the bit layout the exec-stage instruction decoders consume: opcode in bits [7:0], Conv fields up to bit 511.

## Interface
- INS_W, `INS_RAM_DATA_WIDTH` (512): instruction word width.
- BEAT_W, 32: input beat width; INS_W must be a multiple of BEAT_W.
- DEPTH, `INS_RAM_DEPTH` (1024): instruction RAM depth.
- AW, $clog2(DEPTH): RAM address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches base_addr and n_ins. Ignored unless the block is IDLE.
- base_addr  in  AW  RAM address of the first instruction.
- n_ins  in  16  number of instructions to load.
- s_tdata  in  BEAT_W  stream beat.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat accepted when s_tvalid & s_tready.
- s_tlast  in  1  marks the final beat of the final instruction.
- ram_wen  out  1  instruction RAM write enable.
- ram_waddr  out  AW  write address.
- ram_wdata  out  INS_W  write data.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when the load finishes.
- err  out  1  sticky tlast-mismatch flag; cleared by the next accepted start.
- n_written  out  16  instructions written in the current load.

## Operation
- N_BEATS = INS_W/BEAT_W (16 beats at default parameters).
- The beat counter counts from 0 to N_BEATS-1. Beat k lands in word bits [k*BEAT_W +: BEAT_W], so beat 0 carries the opcode in [7:0].
- FSM states: IDLE, COLLECT, WRITE, FIN.
  - IDLE: start loads addr←base_addr, remaining←n_ins, n_written←0, err←0, beat counter←0.
    - If n_ins==0, go to FIN.
    - Otherwise go to COLLECT.
  - COLLECT: s_tready=1. Each handshake stores one beat into the shift/assembly register and increments the beat counter.
    - On the handshake with beat counter==N_BEATS-1, go to WRITE.
    - tlast check on that beat: if s_tlast != (remaining==1), set err. The write still proceeds.
    - s_tlast on any earlier beat also sets err. The beat is still used as data.
  - WRITE: s_tready=0. ram_wen=1 with ram_waddr=addr and ram_wdata=the assembled word.
    - Updates: addr←addr+1 (wraps modulo DEPTH, so DEPTH-1 is followed by 0), remaining−1, n_written+1, beat counter←0.
    - If remaining==1, go to FIN; otherwise go to COLLECT.
  - FIN: done=1 for one cycle, then go to IDLE.
- start is ignored while busy.
- A beat presented while in IDLE or WRITE is not accepted; the source must hold it.

## Timing
- Reset values: s_tready=0, ram_wen=0, ram_waddr=0, ram_wdata=0, busy=0, done=0, err=0, n_written=0, FSM in IDLE.
- start→busy: busy rises the cycle after the start pulse. The first s_tready is also one cycle after start.
- Each instruction takes N_BEATS accepted beats plus one WRITE cycle. Peak throughput is 16 beats per 17 cycles.
- ram_wen is registered and asserts the cycle after the final beat handshake. ram_waddr and ram_wdata are valid in the same cycle as ram_wen and stable only while ram_wen=1.
- done asserts the cycle after the last WRITE. With n_ins==0, done asserts 2 cycles after start.
- s_tvalid may drop between beats: the beat counter holds and nothing is lost.
- Asynchronous reset mid-load: the FSM returns to IDLE immediately and the partial word is discarded. No ram_wen may assert after rstn falls.
- n_written updates in the same cycle as the ram_wen write (visible the next cycle).

## Test plan
- Single Conv word: base_addr=5, n_ins=1, 16 beats 0x00000003, 0x11111111 … (beat 15 with tlast). Required: exactly one ram_wen at addr 5; wdata[7:0]=0x03; wdata[511:480] equals beat 15; done one cycle later; err=0.
- Back-to-back: n_ins=3, continuous valid beats. Required: writes to base, base+1, base+2 at cycles 17, 34, 51 after the first handshake; n_written=3; done pulse.
- Wrap and backpressure: base_addr=DEPTH-1, n_ins=2, s_tvalid toggled every other cycle. Required: writes to DEPTH-1 then 0; data intact; no beat duplicated or dropped.
- tlast errors:
  - tlast on beat 7 of instruction 0 of 2 → err=1, both words still written.
  - Missing tlast on the final beat → err=1.
  - A new start clears err.
- Zero count and start while busy: n_ins=0 → done 2 cycles after start with no ram_wen. A start pulse mid-COLLECT is ignored: base address and count are unchanged.
- Reset mid-instruction: drop rstn after 9 beats. Required: all outputs at reset values immediately, no ram_wen. A fresh start then loads correctly from beat 0.
